// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter with valid/ready load handshake.
// Latency: first serial bit on sdo one cycle after the handshake edge.
//   Back-to-back frames follow each other with no gap.
// Backpressure: load_ready is high in IDLE and on the frame's final cycle only.
//   An offered word is held off (not captured) while load_ready is low.
// Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit per
//   frame. The frame is then WIDTH+1 cycles long, and eof and load_ready move
//   to the parity cycle.
//
// Ports:
//   clk        : clock; all state changes on its rising edge.
//   rst        : asynchronous active-low reset.
//   load_valid : a parallel word is offered.
//   load_data  : the parallel word; captured only on the handshake.
//   load_ready : the block accepts a word this cycle.
//   sdo        : serial data bit; a flop output.
//   sdo_b      : complement of sdo.
//   sdo_valid  : sdo carries a frame bit.
//   sof        : high on the first bit of a frame.
//   eof        : high on the last bit of a frame.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_b,
  output logic             sdo_valid,
  output logic             sof,
  output logic             eof
);

  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int              OUT_IDX  = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic last_bit;
  logic handshake;

  // cnt_q is the index of the bit currently on sdo.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign handshake = load_valid && load_ready;

  // The shift register is cleared whenever the block returns to IDLE. This
  // lets sdo come straight off a flop and still read 0 while idle.
  assign sdo       = shreg_q[OUT_IDX];
  assign sdo_b     = ~shreg_q[OUT_IDX];
  assign sdo_valid = (state_q != IDLE);
  assign sof       = (state_q == SHIFT) && (cnt_q == '0);

`ifdef PISO_TX_PARITY_EN
  assign eof        = (state_q == PARITY);
  assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
  assign eof        = last_bit;
  assign load_ready = (state_q == IDLE) || last_bit;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = SHIFT;
          shreg_d = load_data;
          cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
          parity_d = ^load_data;
`endif
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
          // Park the parity bit in the output position for one cycle.
          state_d          = PARITY;
          shreg_d          = '0;
          shreg_d[OUT_IDX] = parity_q;
`else
          if (handshake) begin
            state_d = SHIFT;
            shreg_d = load_data;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
          end
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        cnt_d = '0;
        if (handshake) begin
          state_d  = SHIFT;
          shreg_d  = load_data;
          parity_d = ^load_data;
        end else begin
          state_d = IDLE;
          shreg_d = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
